// File: rtl/wb_timer_sched_if.sv
// ----------------------------------------------------------------------------
// wb_timer_sched_if
//   Wishbone classic slave bus bundle for the timeout scheduler.
//   Signal names keep the Wishbone _i/_o suffixes as seen from the slave.
//
//   wb_stb_i  strobe              (master -> slave)
//   wb_cyc_i  cycle               (master -> slave)
//   wb_we_i   write enable        (master -> slave)
//   wb_adr_i  byte address [31:0] (master -> slave)
//   wb_sel_i  byte selects [3:0]  (master -> slave)
//   wb_dat_i  write data [31:0]   (master -> slave)
//   wb_ack_o  acknowledge         (slave -> master)
//   wb_dat_o  read data [31:0]    (slave -> master)
// ----------------------------------------------------------------------------
interface wb_timer_sched_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_timer_sched.sv
// ----------------------------------------------------------------------------
// wb_timer_sched
//   Wishbone slave that multiplexes NSLOT software timeout slots onto one
//   shared free-running 32-bit tick counter (NOW). A round-robin scanner
//   checks one slot per clock against NOW, sets per-slot pending bits and
//   re-arms periodic slots. Pending bits gated by IRQMASK drive interrupts.
//
// Ports
//   clk    in   1      system clock
//   reset  in   1      synchronous, active-high reset
//   bus    slave       Wishbone bus (see wb_timer_sched_if)
//   intr   out  NSLOT  per-slot interrupt = PEND & IRQMASK
//   irq    out  1      registered OR of intr
//
// Register map (byte address [7:0], 32-bit accesses only)
//   0x00        NOW       read-only tick counter
//   0x04        PEND      write-1-to-clear pending bits
//   0x08        IRQMASK   bits NSLOT-1:0
//   0x10+16*i   CTRLi     {30'b0, PERIODIC, EN}
//   0x14+16*i   DEADLINEi
//   0x18+16*i   PERIODi
//   Anything else reads 0 and ignores writes.
// ----------------------------------------------------------------------------
module wb_timer_sched #(
  parameter int unsigned clk_freq = 50000000,
  parameter int unsigned tick_hz  = 1000000,
  parameter int unsigned NSLOT    = 4
) (
  input  logic             clk,
  input  logic             reset,
  wb_timer_sched_if.slave  bus,
  output logic [NSLOT-1:0] intr,
  output logic             irq
);

  localparam int unsigned DIV = clk_freq / tick_hz;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(NSLOT - 1);
  localparam logic [3:0]    SLOT_LAST = 4'(NSLOT);

  // Time base
  logic [PW-1:0]    r_presc;
  logic [31:0]      r_now;

  // Slot state
  logic             r_en       [NSLOT];
  logic             r_periodic [NSLOT];
  logic [31:0]      r_deadline [NSLOT];
  logic [31:0]      r_period   [NSLOT];
  logic [NSLOT-1:0] r_pend;
  logic [NSLOT-1:0] r_irqmask;
  logic [SW-1:0]    r_scan;

  // Bus side
  logic             r_ack;
  logic [31:0]      r_dat_o;
  logic             r_irq;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [7:0]  w_a;
  logic        w_acc;
  logic        w_wr;
  logic        w_slot_ok;
  logic [3:0]  w_slot_idx4;
  logic [SW-1:0] w_slot;
  logic [1:0]  w_sub;

  assign w_a         = bus.wb_adr_i[7:0];
  // A new access is taken only while no ack is outstanding, which yields
  // exactly one wait state and alternating ack on held strobes.
  assign w_acc       = bus.wb_stb_i & bus.wb_cyc_i & ~r_ack;
  assign w_wr        = w_acc & bus.wb_we_i;
  assign w_slot_idx4 = w_a[7:4] - 4'd1;
  assign w_slot      = w_slot_idx4[SW-1:0];
  assign w_sub       = w_a[3:2];
  assign w_slot_ok   = (w_a[7:4] != 4'd0) && (w_a[7:4] <= SLOT_LAST) &&
                       (w_sub != 2'd3) && (w_a[1:0] == 2'd0);

  // --------------------------------------------------------------------------
  // Scanner: one slot per cycle. The signed view of NOW - DEADLINE makes a
  // deadline up to 2^31-1 ticks ahead compare correctly across NOW wrap.
  // --------------------------------------------------------------------------
  logic [31:0]      w_diff;
  logic             w_hit;
  logic             w_rearm;
  logic             w_bus_owns_slot;
  logic [NSLOT-1:0] w_hit_mask;
  logic [NSLOT-1:0] w_clr_mask;
  logic [NSLOT-1:0] w_pend_next;

  assign w_diff  = r_now - r_deadline[r_scan];
  assign w_hit   = r_en[r_scan] & ~w_diff[31];
  assign w_rearm = r_periodic[r_scan] && (r_period[r_scan] != 32'd0);
  // A bus write to any register of the slot being scanned overrides the
  // expiry side effects; only the pending bit still records the event.
  assign w_bus_owns_slot = w_wr && w_slot_ok && (w_slot == r_scan);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_hit_mask = '0;
    for (int i = 0; i < int'(NSLOT); i++) begin
      w_hit_mask[i] = w_hit && (r_scan == SW'(i));
    end
  end

  assign w_clr_mask  = (w_wr && (w_a == 8'h04)) ? bus.wb_dat_i[NSLOT-1:0] : '0;
  // Set has priority over a simultaneous write-1-clear of the same bit.
  assign w_pend_next = (r_pend & ~w_clr_mask) | w_hit_mask;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = 32'd0;
    if (w_a == 8'h00) begin
      w_rdata = r_now;
    end else if (w_a == 8'h04) begin
      w_rdata = 32'(r_pend);
    end else if (w_a == 8'h08) begin
      w_rdata = 32'(r_irqmask);
    end else if (w_slot_ok) begin
      case (w_sub)
        2'd0:    w_rdata = {30'd0, r_periodic[w_slot], r_en[w_slot]};
        2'd1:    w_rdata = r_deadline[w_slot];
        2'd2:    w_rdata = r_period[w_slot];
        default: w_rdata = 32'd0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order; later statements
  // in this block intentionally override earlier ones (bus beats scanner).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc   <= '0;
      r_now     <= 32'd0;
      r_scan    <= '0;
      r_pend    <= '0;
      r_irqmask <= '0;
      r_ack     <= 1'b0;
      r_dat_o   <= 32'd0;
      r_irq     <= 1'b0;
      // NOTE: the slot arrays are a handful of flops, not a RAM macro, so
      // they take the reset like any other register.
      for (int i = 0; i < int'(NSLOT); i++) begin
        r_en[i]       <= 1'b0;
        r_periodic[i] <= 1'b0;
        r_deadline[i] <= 32'd0;
        r_period[i]   <= 32'd0;
      end
    end else begin
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_now   <= r_now + 32'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      r_scan <= (r_scan == SCAN_MAX) ? '0 : r_scan + SW'(1);

      r_ack <= w_acc;
      if (w_acc) begin
        r_dat_o <= w_rdata;
      end

      r_pend <= w_pend_next;
      r_irq  <= |(r_pend & r_irqmask);

      if (w_hit && !w_bus_owns_slot) begin
        if (w_rearm) begin
          r_deadline[r_scan] <= r_deadline[r_scan] + r_period[r_scan];
        end else begin
          r_en[r_scan] <= 1'b0;
        end
      end

      if (w_wr) begin
        if (w_a == 8'h08) begin
          r_irqmask <= bus.wb_dat_i[NSLOT-1:0];
        end
        if (w_slot_ok) begin
          case (w_sub)
            2'd0: begin
              r_en[w_slot]       <= bus.wb_dat_i[0];
              r_periodic[w_slot] <= bus.wb_dat_i[1];
            end
            2'd1:    r_deadline[w_slot] <= bus.wb_dat_i;
            2'd2:    r_period[w_slot]   <= bus.wb_dat_i;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.wb_ack_o = bus.wb_stb_i & bus.wb_cyc_i & r_ack;
  assign bus.wb_dat_o = r_dat_o;
  assign intr         = r_pend & r_irqmask;
  assign irq          = r_irq;

  // Address bits above the decoded byte, byte selects and the spare slot
  // index bit carry no meaning here.
  logic w_unused;
  assign w_unused = ^{bus.wb_adr_i[31:8], bus.wb_sel_i, w_slot_idx4};

endmodule

// File: tb/tb_wb_timer_sched.sv
// ----------------------------------------------------------------------------
// tb_wb_timer_sched
//   Directed bench. Main DUT runs with DIV=1 so NOW counts cycles since reset
//   and the scan index equals NOW mod 4; a second DUT with DIV=3 checks the
//   prescaler by reading NOW continuously from reset.
// ----------------------------------------------------------------------------
module tb_wb_timer_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_timer_sched_if bus ();
  wb_timer_sched_if bus2 ();
  logic [3:0] intr, intr2;
  logic       irq, irq2;

  wb_timer_sched #(.clk_freq(50), .tick_hz(50), .NSLOT(4)) u_dut (
    .clk(clk), .reset(reset), .bus(bus), .intr(intr), .irq(irq)
  );

  wb_timer_sched #(.clk_freq(3), .tick_hz(1), .NSLOT(4)) u_dut_div3 (
    .clk(clk), .reset(reset), .bus(bus2), .intr(intr2), .irq(irq2)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
  endtask

  // All bus tasks start and end at posedge+1.
  task automatic wb_xfer(input logic we, input logic [7:0] adr,
                         input logic [31:0] wdat, output logic [31:0] rdat);
    int n;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = {24'h0, adr};
    bus.wb_dat_i = wdat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wb_ack_o && n < 8);
    rdat = bus.wb_dat_o;
    check("ack_latency", n, 2);
    @(posedge clk);
    #1;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic wb_rd(input logic [7:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'h0, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reads NOW, then idles so the next access is taken when NOW mod 4 == r,
  // which with DIV=1 is also the cycle the scanner visits slot r.
  task automatic align(input int r, output logic [31:0] n);
    int k;
    wb_rd(8'h00, n);
    k = (r - int'(n[1:0]) - 2 + 8) % 4;
    idle(k);
  endtask

  // DIV=3 DUT: strobe held from time 0, NOW read every other cycle.
  logic [31:0] div_seen [6];
  int          div_cnt = 0;
  initial begin
    int cyc;
    bus2.wb_stb_i = 1'b1;
    bus2.wb_cyc_i = 1'b1;
    bus2.wb_we_i  = 1'b0;
    bus2.wb_adr_i = 32'h0;
    bus2.wb_sel_i = 4'hF;
    bus2.wb_dat_i = 32'h0;
    for (int i = 0; i < 6; i++) div_seen[i] = 32'hDEAD_BEEF;
    wait (reset == 1'b1);
    wait (reset == 1'b0);
    cyc = 0;
    while (div_cnt < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus2.wb_ack_o) begin
        div_seen[div_cnt] = bus2.wb_dat_o;
        div_cnt++;
      end
    end
  end

  initial begin
    logic [31:0] n, p, d, x;
    logic        found;
    logic [31:0] div_exp [6];

    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 32'h0;
    bus.wb_sel_i = 4'hF;
    bus.wb_dat_i = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_irq", irq, 1'b0);
    check("rst_intr", intr, 4'h0);

    // 1: one-shot slot 0, deadline 20
    wb_wr(8'h14, 32'd20);
    wb_wr(8'h10, 32'd1);
    wb_wr(8'h08, 32'd1);
    found = 1'b0;
    n = 32'd0;
    for (int i = 0; i < 40 && !found; i++) begin
      wb_rd(8'h00, n);
      wb_rd(8'h04, p);
      if (p[0]) found = 1'b1;
    end
    check("t1_found", found, 1'b1);
    check("t1_latency_window", (n >= 32'd19 && n <= 32'd22), 1'b1);
    wb_rd(8'h10, x);
    check("t1_ctrl0_off", x, 32'd0);
    check("t1_intr", intr, 4'h1);
    check("t1_irq", irq, 1'b1);

    // 2: periodic slot 1
    wb_rd(8'h00, n);
    d = n + 32'd30;
    wb_wr(8'h24, d);
    wb_wr(8'h28, 32'd40);
    wb_wr(8'h20, 32'd3);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      wb_rd(8'h04, p);
      if (p[1]) found = 1'b1;
    end
    check("t2_first_found", found, 1'b1);
    wb_rd(8'h24, x);
    check("t2_deadline1", x, d + 32'd40);
    wb_wr(8'h04, 32'd2);
    wb_rd(8'h04, p);
    check("t2_w1c", p, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      wb_rd(8'h04, p);
      if (p[1]) found = 1'b1;
    end
    check("t2_second_found", found, 1'b1);
    wb_rd(8'h24, x);
    check("t2_deadline2", x, d + 32'd80);
    wb_rd(8'h20, x);
    check("t2_ctrl1_kept", x, 32'd3);
    wb_wr(8'h20, 32'd0);

    // 3: modular compare across the 32-bit wrap
    wb_rd(8'h00, n);
    wb_wr(8'h34, n + 32'h7FFF_0000);
    wb_wr(8'h30, 32'd1);
    idle(20);
    wb_rd(8'h04, p);
    check("t3_far_future_idle", p[2], 1'b0);
    wb_rd(8'h30, x);
    check("t3_ctrl2_armed", x, 32'd1);
    wb_wr(8'h34, 32'hFFFF_FFF0);
    idle(8);
    wb_rd(8'h04, p);
    check("t3_past_wrap_fires", p[2], 1'b1);
    wb_rd(8'h30, x);
    check("t3_ctrl2_off", x, 32'd0);

    // Periodic with PERIOD=0 behaves as one-shot
    wb_wr(8'h40, 32'd3);
    idle(6);
    wb_rd(8'h40, x);
    check("period0_oneshot_ctrl3", x, 32'd2);
    wb_rd(8'h04, p);
    check("pend_all", p, 32'hF);
    wb_wr(8'h04, 32'hF);
    wb_rd(8'h04, p);
    check("pend_cleared", p, 32'h0);

    // 4: same-cycle collisions on slot 0 (lagging periodic, hits every visit)
    wb_rd(8'h00, n);
    wb_wr(8'h18, 32'd1);
    wb_wr(8'h14, n - 32'd10000);
    wb_wr(8'h10, 32'd3);
    idle(4);
    align(0, n);
    wb_wr(8'h04, 32'd1);
    wb_rd(8'h04, p);
    check("t4_set_beats_w1c", p[0], 1'b1);
    align(2, n);
    wb_wr(8'h04, 32'd1);
    wb_rd(8'h04, p);
    check("t4_w1c_off_phase", p[0], 1'b0);
    align(0, n);
    d = n + 32'h0010_0000;
    wb_wr(8'h14, d);
    wb_rd(8'h14, x);
    check("t4_bus_beats_rearm", x, d);
    wb_wr(8'h10, 32'd0);

    // 5: handshake and unmapped space
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 32'h08;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_b2b_ack", bus.wb_ack_o, (i % 2 == 1) ? 1'b1 : 1'b0);
    end
    @(posedge clk);
    #1;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    wb_rd(8'h50, x);
    check("t5_rd_0x50", x, 32'd0);
    wb_rd(8'h0C, x);
    check("t5_rd_0x0c", x, 32'd0);
    wb_rd(8'h1C, x);
    check("t5_rd_0x1c", x, 32'd0);
    wb_wr(8'h50, 32'hFFFF_FFFF);
    wb_wr(8'h0C, 32'hFFFF_FFFF);
    wb_wr(8'h1C, 32'hFFFF_FFFF);
    wb_rd(8'h50, x);
    check("t5_rd_0x50_after_wr", x, 32'd0);
    wb_rd(8'h08, x);
    check("t5_irqmask_untouched", x, 32'd1);
    wb_rd(8'h14, x);
    check("t5_deadline0_untouched", x, d);
    wb_wr(8'h08, 32'hFFFF_FFFF);
    wb_rd(8'h08, x);
    check("t5_irqmask_width", x, 32'hF);
    wb_wr(8'h00, 32'd0);
    wb_rd(8'h00, n);
    check("t5_now_readonly", (n > 32'd100), 1'b1);

    // 6: reset during an outstanding write
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 32'h08;
    bus.wb_dat_i = 32'h5;
    reset = 1'b1;
    @(negedge clk);
    check("t6_no_ack_pre", bus.wb_ack_o, 1'b0);
    @(negedge clk);
    check("t6_no_ack_post", bus.wb_ack_o, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    wb_rd(8'h00, x);
    check("t6_now", x, 32'd0);
    wb_rd(8'h04, x);
    check("t6_pend", x, 32'd0);
    wb_rd(8'h08, x);
    check("t6_irqmask", x, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wb_rd(8'(8'h10 + 16 * i), x);
      check("t6_ctrl", x, 32'd0);
    end
    wb_rd(8'h14, x);
    check("t6_deadline0", x, 32'd0);
    wb_rd(8'h28, x);
    check("t6_period1", x, 32'd0);
    wb_rd(8'h34, x);
    check("t6_deadline2", x, 32'd0);
    check("t6_intr", intr, 4'h0);
    check("t6_irq", irq, 1'b0);

    // DIV=3 prescaler: NOW sampled on every other cycle from reset
    div_exp[0] = 32'd0; div_exp[1] = 32'd0; div_exp[2] = 32'd1;
    div_exp[3] = 32'd2; div_exp[4] = 32'd2; div_exp[5] = 32'd3;
    check("div3_reads", div_cnt, 6);
    for (int i = 0; i < 6; i++) check("div3_now", div_seen[i], div_exp[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
